// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step arbiter: FSM encoding, Gray constants
// and the 3-bit Gray successor function.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] GRAY_ZERO = 3'b000;
  localparam logic [2:0] GRAY_LAST = 3'b100;

  // Successor in the cycle 000-001-011-010-110-111-101-100-000
  function automatic logic [2:0] gray_next(input logic [2:0] g);
    logic [2:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = GRAY_ZERO;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gray_step.sv
// Shared 3-bit Gray step counter with wrap pulse and sticky overflow flag.
// Clear wins over enable; the arbiter never asserts both together anyway.
module gray_step
  import gray_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic       Clr,
  output logic [2:0] Code,
  output logic       Wrap,
  output logic       Overflow
);

  logic at_last;

  assign at_last = (Code == GRAY_LAST);

  // Step the Gray value; Wrap/Overflow are registered alongside Code
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Code     <= GRAY_ZERO;
      Wrap     <= 1'b0;
      Overflow <= 1'b0;
    end else if (Clr) begin
      Code     <= GRAY_ZERO;
      Wrap     <= 1'b0;
      Overflow <= 1'b0;
    end else if (En) begin
      Code     <= gray_next(Code);
      Wrap     <= at_last;
      Overflow <= Overflow | at_last;
    end else begin
      Wrap     <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_seq_arbiter.sv
// Round-robin owner of the shared Gray step counter. Each grant runs a burst
// of Len steps, then pulses Done to the owner for one cycle.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; pick next requester at/after ptr, honour Clr
//   RUN     | owner holds Gnt; one Code step per cycle while rem != 0
//   DONE    | last step visible on Code; Done pulse to owner, advance ptr
module gray_seq_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*LEN_W-1:0] Len,
  input  logic                   Clr,
  output logic [N_REQ-1:0]       Gnt,
  output logic                   Busy,
  output logic [N_REQ-1:0]       Done,
  output logic [2:0]             Code,
  output logic                   Wrap,
  output logic                   Overflow
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state;
  logic [LEN_W-1:0]   rem;
  logic [IDX_W-1:0]   own;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   own_inc;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_valid;
  logic               step_en;
  logic               clr_en;
  logic [LEN_W-1:0]   len_arr [N_REQ];

  // Split the packed length bus into per-requester fields
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      len_arr[i] = Len[i*LEN_W +: LEN_W];
    end
  end

  // Cyclic first-set search starting at ptr; lowest offset is written last and wins
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (Req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Counter controls: abort suppresses the step; Clr only counts in IDLE
  always_comb begin
    own_inc = (own == IDX_W'(N_REQ - 1)) ? '0 : own + IDX_W'(1);
    step_en = (state == ST_RUN) && Req[own] && (rem != '0);
    clr_en  = (state == ST_IDLE) && Clr;
  end

  // Sequencing FSM with registered Gnt/Busy/Done
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      own   <= '0;
      ptr   <= '0;
      Gnt   <= '0;
      Busy  <= 1'b0;
      Done  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            state <= ST_RUN;
            rem   <= len_arr[sel_idx];
            own   <= sel_idx;
            Gnt   <= N_REQ'(1) << sel_idx;
            Busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!Req[own]) begin
            state <= ST_IDLE;
            Gnt   <= '0;
            Busy  <= 1'b0;
            ptr   <= own_inc;
          end else if (rem != '0) begin
            rem <= rem - LEN_W'(1);
            // Final step lands on Code in the same cycle DONE is entered
            if (rem == LEN_W'(1)) begin
              state <= ST_DONE;
              Done  <= Gnt;
            end
          end else begin
            state <= ST_DONE;
            Done  <= Gnt;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Gnt   <= '0;
          Busy  <= 1'b0;
          Done  <= '0;
          ptr   <= own_inc;
        end
        default: begin
          state <= ST_IDLE;
          Gnt   <= '0;
          Busy  <= 1'b0;
          Done  <= '0;
        end
      endcase
    end
  end

  gray_step u_step (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (step_en),
    .Clr      (clr_en),
    .Code     (Code),
    .Wrap     (Wrap),
    .Overflow (Overflow)
  );

endmodule

// File: tb/tb_gray_seq_arbiter.sv
// Directed bench for gray_seq_arbiter: inputs driven and outputs sampled 1ns
// after each rising edge.
module tb_gray_seq_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Req;
  logic [11:0] Len;
  logic        Clr;
  logic [3:0]  Gnt;
  logic        Busy;
  logic [3:0]  Done;
  logic [2:0]  Code;
  logic        Wrap;
  logic        Overflow;

  int checks;
  int failures;
  logic [2:0] gseq [8];

  gray_seq_arbiter #(.N_REQ(4), .LEN_W(3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Len      (Len),
    .Clr      (Clr),
    .Gnt      (Gnt),
    .Busy     (Busy),
    .Done     (Done),
    .Code     (Code),
    .Wrap     (Wrap),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Req   = '0;
    Clr   = 1'b0;
    Len   = '0;
    #1;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Req   = '0;
    Clr   = 1'b0;
    Len   = '0;
    #2;
    checks++;
    if ({Gnt, Busy, Done, Code, Wrap, Overflow} !== 14'd0) begin
      failures++;
      $display("FAIL reset_hold: got %b want %b", {Gnt, Busy, Done, Code, Wrap, Overflow}, 14'd0);
    end
    tick();
    Reset = 1'b1;
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code, Wrap, Overflow} !== 14'd0) begin
      failures++;
      $display("FAIL reset_idle: got %b want %b", {Gnt, Busy, Done, Code, Wrap, Overflow}, 14'd0);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    Req = 4'b0001;
    Len[2:0] = 3'd3;
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code} !== {4'b0001, 1'b1, 4'b0000, 3'b000}) begin
      failures++;
      $display("FAIL single_c1: got %b want %b", {Gnt, Busy, Done, Code}, {4'b0001, 1'b1, 4'b0000, 3'b000});
    end
    tick();
    checks++;
    if ({Done, Code} !== {4'b0000, 3'b001}) begin
      failures++;
      $display("FAIL single_c2: got %b want %b", {Done, Code}, {4'b0000, 3'b001});
    end
    tick();
    checks++;
    if ({Done, Code} !== {4'b0000, 3'b011}) begin
      failures++;
      $display("FAIL single_c3: got %b want %b", {Done, Code}, {4'b0000, 3'b011});
    end
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code} !== {4'b0001, 1'b1, 4'b0001, 3'b010}) begin
      failures++;
      $display("FAIL single_c4: got %b want %b", {Gnt, Busy, Done, Code}, {4'b0001, 1'b1, 4'b0001, 3'b010});
    end
    Req = 4'b0000;
    tick();
    checks++;
    if ({Gnt, Busy, Done} !== 9'd0) begin
      failures++;
      $display("FAIL single_c5: got %b want %b", {Gnt, Busy, Done}, 9'd0);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    Req = 4'b1111;
    Len = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int b = 0; b < 5; b++) begin
      exp_oh = 4'b0001 << (b % 4);
      tick();
      checks++;
      if ({Gnt, Done} !== {exp_oh, 4'b0000}) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b", b, {Gnt, Done}, {exp_oh, 4'b0000});
      end
      tick();
      checks++;
      if ({Gnt, Done, Code} !== {exp_oh, exp_oh, gseq[b + 1]}) begin
        failures++;
        $display("FAIL rr_done[%0d]: got %b want %b", b, {Gnt, Done, Code}, {exp_oh, exp_oh, gseq[b + 1]});
      end
      tick();
      checks++;
      if ({Gnt, Busy} !== 5'd0) begin
        failures++;
        $display("FAIL rr_idle[%0d]: got %b want %b", b, {Gnt, Busy}, 5'd0);
      end
    end
    Req = 4'b0000;
    tick();
    checks++;
    if ({Gnt, Busy, Code} !== {4'b0000, 1'b0, 3'b111}) begin
      failures++;
      $display("FAIL rr_end: got %b want %b", {Gnt, Busy, Code}, {4'b0000, 1'b0, 3'b111});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    Req = 4'b0001;
    Len[2:0] = 3'd5;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({Done, Code, Wrap, Overflow} !== {4'b0001, 3'b111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wrap_first_done: got %b want %b", {Done, Code, Wrap, Overflow}, {4'b0001, 3'b111, 1'b0, 1'b0});
    end
    Req = 4'b0010;
    Len[5:3] = 3'd3;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if ({Gnt, Code, Wrap, Overflow} !== {4'b0010, 3'b100, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wrap_pre: got %b want %b", {Gnt, Code, Wrap, Overflow}, {4'b0010, 3'b100, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({Done, Code, Wrap, Overflow} !== {4'b0010, 3'b000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL wrap_pulse: got %b want %b", {Done, Code, Wrap, Overflow}, {4'b0010, 3'b000, 1'b1, 1'b1});
    end
    Req = 4'b0000;
    tick();
    checks++;
    if ({Busy, Code, Wrap, Overflow} !== {1'b0, 3'b000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_sticky: got %b want %b", {Busy, Code, Wrap, Overflow}, {1'b0, 3'b000, 1'b0, 1'b1});
    end
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    checks++;
    if ({Code, Wrap, Overflow} !== {3'b000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wrap_clr: got %b want %b", {Code, Wrap, Overflow}, {3'b000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    Req = 4'b0001;
    Len[2:0] = 3'd2;
    tick();
    tick();
    tick();
    Req = 4'b0000;
    tick();
    Req = 4'b0100;
    Len[8:6] = 3'd0;
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code} !== {4'b0100, 1'b1, 4'b0000, 3'b011}) begin
      failures++;
      $display("FAIL len0_run: got %b want %b", {Gnt, Busy, Done, Code}, {4'b0100, 1'b1, 4'b0000, 3'b011});
    end
    tick();
    checks++;
    if ({Gnt, Done, Code, Wrap} !== {4'b0100, 4'b0100, 3'b011, 1'b0}) begin
      failures++;
      $display("FAIL len0_done: got %b want %b", {Gnt, Done, Code, Wrap}, {4'b0100, 4'b0100, 3'b011, 1'b0});
    end
    Req = 4'b0000;
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code} !== {4'b0000, 1'b0, 4'b0000, 3'b011}) begin
      failures++;
      $display("FAIL len0_idle: got %b want %b", {Gnt, Busy, Done, Code}, {4'b0000, 1'b0, 4'b0000, 3'b011});
    end
  endtask

  task automatic test_abort();
    do_reset();
    Req = 4'b1100;
    Len[8:6]  = 3'd5;
    Len[11:9] = 3'd1;
    tick();
    checks++;
    if (Gnt !== 4'b0100) begin
      failures++;
      $display("FAIL abort_grant: got %b want %b", Gnt, 4'b0100);
    end
    tick();
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    checks++;
    if (Code !== 3'b011) begin
      failures++;
      $display("FAIL abort_clr_ignored: got %b want %b", Code, 3'b011);
    end
    Req = 4'b1000;
    tick();
    checks++;
    if ({Gnt, Busy, Done, Code} !== {4'b0000, 1'b0, 4'b0000, 3'b011}) begin
      failures++;
      $display("FAIL abort_idle: got %b want %b", {Gnt, Busy, Done, Code}, {4'b0000, 1'b0, 4'b0000, 3'b011});
    end
    tick();
    checks++;
    if (Gnt !== 4'b1000) begin
      failures++;
      $display("FAIL abort_next_owner: got %b want %b", Gnt, 4'b1000);
    end
    tick();
    checks++;
    if ({Done, Code} !== {4'b1000, 3'b010}) begin
      failures++;
      $display("FAIL abort_next_done: got %b want %b", {Done, Code}, {4'b1000, 3'b010});
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    Req = 4'b0100;
    Len[8:6] = 3'd0;
    tick();
    tick();
    Req = 4'b0000;
    tick();
    Req = 4'b1000;
    Len[11:9] = 3'd7;
    tick();
    tick();
    tick();
    checks++;
    if ({Gnt, Busy, Code} !== {4'b1000, 1'b1, 3'b011}) begin
      failures++;
      $display("FAIL arst_pre: got %b want %b", {Gnt, Busy, Code}, {4'b1000, 1'b1, 3'b011});
    end
    #1;
    Reset = 1'b0;
    Req   = 4'b1010;
    #1;
    checks++;
    if ({Gnt, Busy, Done, Code, Wrap, Overflow} !== 14'd0) begin
      failures++;
      $display("FAIL arst_async: got %b want %b", {Gnt, Busy, Done, Code, Wrap, Overflow}, 14'd0);
    end
    #3;
    Reset = 1'b1;
    tick();
    checks++;
    if ({Gnt, Busy, Done} !== {4'b0010, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL arst_regrant: got %b want %b", {Gnt, Busy, Done}, {4'b0010, 1'b1, 4'b0000});
    end
    Req = 4'b0000;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wrap();
    test_len_zero();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_seq_arbiter.md
# gray_seq_arbiter

Round-robin controller that shares one 3-bit Gray-code step counter among up to N_REQ requesters. Each granted requester receives a burst of Len steps. The controller sequences the counter's enable, reports the burst's completion, and tracks wrap-around. It sits between requester FSMs and the shared Gray counter, replacing direct En drive from any single client.

## Interface
- N_REQ, 4: number of requesters (2..8).
- LEN_W, 3: width of each per-requester step-count field.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- Req  in  N_REQ  request, one bit per requester; must be held until Done or the requester aborts.
- Len  in  N_REQ*LEN_W  steps requested; field i is Len[i*LEN_W +: LEN_W]; sampled only at grant.
- Clr  in  1  synchronous clear of Code and Overflow; honoured only in IDLE.
- Gnt  out  N_REQ  one-hot owner, registered; reset 0.
- Busy  out  1  high in RUN and DONE; reset 0.
- Done  out  N_REQ  one-cycle pulse to the owner when its burst completes; reset 0.
- Code  out  3  current Gray value; reset 3'b000.
- Wrap  out  1  one-cycle pulse in the cycle Code becomes 000 by stepping from 100; reset 0.
- Overflow  out  1  sticky; set on any Wrap, cleared by Reset or an honoured Clr; reset 0.

## Operation
- Gray sequence: 000→001→011→010→110→111→101→100→000, repeating.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any Req bit is high, select the first set bit at or after Ptr, searching cyclically.
  - Latch that bit's Len field into Rem and the index into Own; go to RUN.
  - With no Req, stay in IDLE.
- RUN:
  - Gnt[Own]=1.
  - If Req[Own]=0, abort: go to IDLE with no Done, Code holds, Ptr=Own+1.
  - Else if Rem≠0: step Code, Rem−=1.
  - Else (Rem=0): go to DONE.
  - Abort takes priority over stepping in the same cycle.
- DONE:
  - Done[Own]=1 and Gnt[Own]=1 for exactly one cycle.
  - Ptr=(Own+1) mod N_REQ; next state IDLE.
- Rem is LEN_W bits. Len=0 means zero steps: RUN→DONE with no Code change.
- Clr in IDLE sets Code=000 and Overflow=0 at the next edge. Clr is ignored in RUN and DONE.
- Clr together with a grant in the same IDLE cycle: both take effect, and the burst starts from 000.
- Ptr resets to 0.
- Code is preserved across bursts, so owners continue the shared sequence.
- Reset mid-burst returns to IDLE with all outputs at reset values; the burst is lost with no Done.
- Req bits of non-owners are ignored until the FSM is back in IDLE.

## Timing
- Req sampled high in IDLE cycle t → Gnt high from cycle t+1.
- Len=k≥1:
  - RUN occupies cycles t+1..t+k, and Code changes at the end of each of those cycles.
  - The k-th new value is visible in cycle t+k+1, which is the DONE cycle, with Done high.
  - IDLE in cycle t+k+2; the next Gnt appears no earlier than cycle t+k+3.
- Len=0: RUN in t+1, DONE in t+2.
- Wrap and Overflow are registered with Code: Wrap is high in the same cycle Code first reads 000 after 100.
- Gnt, Done, Busy, Code, Wrap and Overflow are all registered, with no combinational path from inputs.

## Structure
- Shared package gray_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - the 3-bit Gray next-value function;
  - the constants GRAY_ZERO=000 and GRAY_LAST=100.
- Sub-module gray_step holds Code, Wrap and Overflow.
  - Inputs: Clk, Reset, En, Clr.
  - Outputs: Code, Wrap, Overflow.
- The top level keeps the FSM, Rem, Own, Ptr and the round-robin selector.

## Test plan
- Reset, then Req=0001 with Len[0]=3 → Gnt=0001 in cycle 1; Code 001,011,010 in cycles 2,3,4; Done[0] pulse in cycle 4; Busy low in cycle 5.
- Req=1111 with all Len=1, held → grants in order 0,1,2,3,0; each burst advances Code by one step; Ptr rotation is checked.
- Run 8 total steps from 000 via Len=5 then Len=3 → Code returns to 000; Wrap pulses in that cycle; Overflow=1 and stays 1; Clr in IDLE clears Overflow and keeps Code=000.
- Len=0 request → Gnt for 2 cycles, Done pulse, Code unchanged, Wrap=0.
- Drop Req[2] mid-RUN after 2 of 5 steps → no Done; Code advanced by exactly 2; next grant goes to requester 3 if pending; Clr asserted during RUN has no effect.
- Assert Reset low mid-burst → Gnt, Busy, Done, Code and Overflow go to 0 asynchronously before the next edge; after release, Req[1] alone is granted first.
